// File: rtl/phase_dec_pkg.sv
// Shared types and constants for the phase-encoded line decoder.
// Also carries the encoder line model used to drive stimulus.
package phase_dec_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_e;

  localparam int BYTE_W       = 8;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_ERR_W    = 8;

  // Returns {t1, t2} for encoder state (p, q) and data bit x.
  function automatic logic [1:0] enc_line(
    input logic p,
    input logic q,
    input logic x
  );
    return {~p, x ^ ~(p ^ q)};
  endfunction

endpackage

// File: rtl/phase_deser.sv
// LSB-first deserializer: packs recovered bits into bytes.
// Clear discards the partial byte; byte_out holds until the next one completes.
module phase_deser
  import phase_dec_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              clear,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_vld
);

  localparam int CW = $clog2(BYTE_W);

  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              vld_q, vld_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    vld_d     = 1'b0;
    if (clear) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
    end else if (shift_en) begin
      shreg_d[bit_cnt_q] = bit_in;
      if (bit_cnt_q == CW'(BYTE_W - 1)) begin
        byte_d    = shreg_d;
        vld_d     = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      byte_q    <= '0;
      vld_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      vld_q     <= vld_d;
    end
  end

  assign byte_out = byte_q;
  assign byte_vld = vld_q;

endmodule

// File: rtl/phase_decoder.sv
// Receive-side decoder for the 2-bit phase line: recovers bits,
// locks on t1 alternation, counts phase errors and assembles bytes.
module phase_decoder
  import phase_dec_pkg::*;
#(
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              t1,
  input  logic              t2,
  output logic              x,
  output logic              x_vld,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_vld,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  sync_state_e      state_q, state_d;
  logic [3:0]       alt_q, alt_d;
  logic             t1_d_q, t2_d_q;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             alt;
  logic             x_hat;
  logic             shift_en;
  logic             clear;

  assign alt   = (t1 != t1_d_q);
  assign x_hat = t2 ^ t1 ^ t2_d_q;

  always_comb begin
    state_d  = state_q;
    alt_d    = alt_q;
    x_d      = x_q;
    xv_d     = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      HUNT: begin
        clear = 1'b1;
        if (!alt) begin
          alt_d = '0;
        end else if (alt_q == 4'(LOCK_CNT - 1)) begin
          alt_d   = '0;
          state_d = LOCKED;
        end else begin
          alt_d = alt_q + 4'd1;
        end
      end
      LOCKED: begin
        if (alt) begin
          x_d      = x_hat;
          xv_d     = 1'b1;
          shift_en = 1'b1;
        end else begin
          // Phase slip: drop the partial byte and hunt again.
          err_d   = 1'b1;
          clear   = 1'b1;
          alt_d   = '0;
          state_d = HUNT;
          if (cnt_q != {ERR_W{1'b1}}) begin
            cnt_d = cnt_q + ERR_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= HUNT;
      alt_q   <= '0;
      t1_d_q  <= 1'b0;
      t2_d_q  <= 1'b0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alt_q   <= alt_d;
      t1_d_q  <= t1;
      t2_d_q  <= t2;
      x_q     <= x_d;
      xv_q    <= xv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  phase_deser u_deser (
    .clk      (clk),
    .res      (res),
    .shift_en (shift_en),
    .bit_in   (x_hat),
    .clear    (clear),
    .byte_out (byte_out),
    .byte_vld (byte_vld)
  );

  assign x       = x_q;
  assign x_vld   = xv_q;
  assign locked  = (state_q == LOCKED);
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Directed bench for phase_decoder: lock table, byte stream,
// phase errors, async reset and a 2-bit saturating error counter.
module tb_phase_decoder;
  import phase_dec_pkg::*;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       t1  = 1'b0;
  logic       t2  = 1'b0;

  logic       x, x_vld, byte_vld, locked, err;
  logic [7:0] byte_out, err_cnt;

  logic       sx, sx_vld, sbyte_vld, slocked, serr;
  logic [7:0] sbyte_out;
  logic [1:0] serr_cnt;

  int checks   = 0;
  int failures = 0;
  int n_err    = 0;
  logic ep = 1'b0;
  logic eq = 1'b0;

  typedef struct {
    logic t1;
    logic t2;
    logic x;
    logic xv;
    logic lk;
    logic er;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  phase_decoder dut (
    .clk(clk), .res(res), .t1(t1), .t2(t2),
    .x(x), .x_vld(x_vld),
    .byte_out(byte_out), .byte_vld(byte_vld),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  phase_decoder #(.LOCK_CNT(4), .ERR_W(2)) u_sat (
    .clk(clk), .res(res), .t1(t1), .t2(t2),
    .x(sx), .x_vld(sx_vld),
    .byte_out(sbyte_out), .byte_vld(sbyte_vld),
    .locked(slocked), .err(serr), .err_cnt(serr_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b);
    t1 = a;
    t2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic enc(input logic xb);
    logic [1:0] l;
    l  = enc_line(ep, eq, xb);
    ep = ~ep;
    eq = l[0];
    drive(l[1], l[0]);
  endtask

  // Repeats the previous line sample; encoder state is not advanced.
  task automatic glitch();
    drive(t1, t2);
    n_err++;
  endtask

  task automatic relock();
    for (int i = 0; i < 4; i++) begin
      enc(1'($urandom_range(0, 1)));
      chk("hunt_xvld", x_vld, 0);
      chk("hunt_err", err, 0);
      chk("hunt_lock", locked, (i == 3));
    end
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input int lo, input int hi,
                           input logic [7:0] prev);
    for (int k = lo; k <= hi; k++) begin
      enc(b[k]);
      chk("x_vld", x_vld, 1);
      chk("x", x, b[k]);
      chk("byte_vld", byte_vld, (k == 7));
      chk("byte_out", byte_out, (k == 7) ? b : prev);
      chk("no_err", err, 0);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_xvld", x_vld, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_bvld", byte_vld, 0);
    chk("rst_lock", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    res = 1'b1;

    // Lock from reset with x=0 on every encoder cycle.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].t1, tbl[i].t2);
      chk("tbl_lock", locked, tbl[i].lk);
      chk("tbl_xvld", x_vld, tbl[i].xv);
      chk("tbl_err", err, tbl[i].er);
      if (tbl[i].xv) chk("tbl_x", x, tbl[i].x);
    end
    ep = 1'b0;
    eq = tbl[5].t2;

    // Bits 0,1 of a zero byte are already in; finish it, then two bytes.
    send_bits(8'h00, 2, 7, 8'h00);
    send_bits(8'hA5, 0, 7, 8'h00);
    send_bits(8'h3C, 0, 7, 8'hA5);

    // Phase error at bit_cnt=5.
    send_bits(8'h96, 0, 4, 8'h3C);
    glitch();
    chk("pe_err", err, 1);
    chk("pe_cnt", err_cnt, 1);
    chk("pe_lock", locked, 0);
    chk("pe_xvld", x_vld, 0);
    chk("pe_bvld", byte_vld, 0);
    relock();
    send_bits(8'h5A, 0, 7, 8'h3C);

    // Phase error on the sample that would complete a byte.
    send_bits(8'hFF, 0, 6, 8'h5A);
    glitch();
    chk("b7_err", err, 1);
    chk("b7_bvld", byte_vld, 0);
    chk("b7_byte", byte_out, 8'h5A);
    chk("b7_cnt", err_cnt, 2);
    relock();
    send_bits(8'h81, 0, 7, 8'h5A);

    // Async reset between edges with 3 bits held.
    send_bits(8'h77, 0, 2, 8'h81);
    #2 res = 1'b0;
    #1;
    chk("ar_x", x, 0);
    chk("ar_xvld", x_vld, 0);
    chk("ar_byte", byte_out, 0);
    chk("ar_bvld", byte_vld, 0);
    chk("ar_lock", locked, 0);
    chk("ar_err", err, 0);
    chk("ar_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    chk("ar_hold_xvld", x_vld, 0);
    chk("ar_hold_lock", locked, 0);
    res = 1'b1;
    ep = 1'b0;
    eq = 1'b0;
    n_err = 0;
    relock();
    send_bits(8'hC3, 0, 7, 8'h00);

    // Five errors, each followed by a re-lock.
    for (int e = 1; e <= 5; e++) begin
      send_bits(8'h02, 0, 1, 8'hC3);
      glitch();
      chk("sat_err", serr, 1);
      chk("sat_cnt", serr_cnt, (n_err > 3) ? 3 : n_err);
      chk("wide_cnt", err_cnt, n_err);
      relock();
      chk("sat_relock", slocked, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
